// File: rtl/sampling_pkg.sv
// Shared defaults and helpers for the DDS sample-rate controller:
// divider ratio per mode and wrapping mode arithmetic.
package sampling_pkg;

  localparam int NUM_MODES_DEF = 5;
  localparam int RADIX_DEF     = 10;

  // Kinds of pending-target update, in decreasing priority.
  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_LOAD,
    REQ_UP,
    REQ_DOWN
  } req_e;

  // RADIX**m, evaluated at elaboration time to build the ratio table.
  function automatic int div_of(input int radix, input int m);
    int r;
    r = 1;
    for (int i = 0; i < m; i++) begin
      r = r * radix;
    end
    return r;
  endfunction

  function automatic int mode_wrap_inc(input int m, input int num_modes);
    return (m >= num_modes - 1) ? 0 : m + 1;
  endfunction

  function automatic int mode_wrap_dec(input int m, input int num_modes);
    return (m == 0) ? num_modes - 1 : m - 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: two-flop synchroniser, stability counter and
// a single press pulse when a new high level is accepted.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic Fg_CLK,
  input  logic RESET,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] stable_cnt_reg;
  logic          accept;

  // The synchronised level must disagree with the accepted level for
  // DEBOUNCE_CYCLES consecutive cycles before it is taken.
  assign accept = (sync2_reg != level_reg) &&
                  (stable_cnt_reg == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      level_reg      <= 1'b0;
      press_reg      <= 1'b0;
      stable_cnt_reg <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      if (sync2_reg == level_reg) begin
        stable_cnt_reg <= '0;
      end else if (accept) begin
        stable_cnt_reg <= '0;
        level_reg      <= sync2_reg;
      end else begin
        stable_cnt_reg <= stable_cnt_reg + 1'b1;
      end
      press_reg <= accept && sync2_reg;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/sampling_rate_ctrl.sv
// Sample-rate controller: divides Fg_CLK by RADIX**Mode, emits one Enable per
// sample and applies mode requests only on sample boundaries.
module sampling_rate_ctrl
  import sampling_pkg::*;
#(
  parameter int NUM_MODES       = NUM_MODES_DEF,
  parameter int RADIX           = RADIX_DEF,
  parameter int MODE_W          = 4,
  parameter int CNT_W           = 15,
  parameter int READY_CYCLES    = 80,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic              Fg_CLK,
  input  logic              RESET,
  input  logic              BtnUp,
  input  logic              BtnDown,
  input  logic              ModeLoad,
  input  logic [MODE_W-1:0] ModeIn,
  output logic              Ready,
  output logic              Enable,
  output logic [MODE_W-1:0] Mode,
  output logic              ModeChanged,
  output logic [CNT_W-1:0]  DivRatio
);

  localparam int RW      = $clog2(READY_CYCLES + 1);
  localparam int TABLE_N = 2 ** MODE_W;

  logic [RW-1:0]     ready_cnt_reg;
  logic              ready_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              enable_reg;
  logic [MODE_W-1:0] mode_reg;
  logic [MODE_W-1:0] tgt_reg;
  logic [MODE_W-1:0] tgt_next;
  logic [CNT_W-1:0]  div_ratio_reg;
  logic              apply_d_reg;
  logic              mode_changed_reg;

  logic              up_press;
  logic              down_press;
  logic              period_end;
  logic              apply;
  logic [MODE_W-1:0] mode_in_sat;
  req_e              req;
  logic [CNT_W-1:0]  div_table [TABLE_N];

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .Fg_CLK (Fg_CLK),
    .RESET  (RESET),
    .btn    (BtnUp),
    .press  (up_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .Fg_CLK (Fg_CLK),
    .RESET  (RESET),
    .btn    (BtnDown),
    .press  (down_press)
  );

  // Unreachable table slots repeat the slowest ratio so the index is total.
  genvar gi;
  generate
    for (gi = 0; gi < TABLE_N; gi++) begin : g_div
      if (gi < NUM_MODES) begin : g_valid
        assign div_table[gi] = CNT_W'(div_of(RADIX, gi));
      end else begin : g_pad
        assign div_table[gi] = CNT_W'(div_of(RADIX, NUM_MODES - 1));
      end
    end
  endgenerate

  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      ready_cnt_reg <= '0;
      ready_reg     <= 1'b0;
    end else if (!ready_reg) begin
      if (ready_cnt_reg == RW'(READY_CYCLES - 1)) begin
        ready_reg <= 1'b1;
      end
      ready_cnt_reg <= ready_cnt_reg + 1'b1;
    end
  end

  assign mode_in_sat = (int'(ModeIn) >= NUM_MODES) ? MODE_W'(NUM_MODES - 1) : ModeIn;

  always_comb begin
    req = REQ_NONE;
    if (ready_reg) begin
      if (ModeLoad) begin
        req = REQ_LOAD;
      end else if (up_press && !down_press) begin
        req = REQ_UP;
      end else if (down_press && !up_press) begin
        req = REQ_DOWN;
      end
    end
  end

  always_comb begin
    tgt_next = tgt_reg;
    case (req)
      REQ_LOAD: tgt_next = mode_in_sat;
      REQ_UP:   tgt_next = MODE_W'(mode_wrap_inc(int'(tgt_reg), NUM_MODES));
      REQ_DOWN: tgt_next = MODE_W'(mode_wrap_dec(int'(tgt_reg), NUM_MODES));
      default:  tgt_next = tgt_reg;
    endcase
  end

  // A mode switch rides on the last count of the current period, so the
  // period in flight always completes and Enable keeps its rhythm.
  assign period_end = (cnt_reg == div_ratio_reg - 1'b1);
  assign apply      = period_end && (tgt_reg != mode_reg);

  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      cnt_reg          <= '0;
      enable_reg       <= 1'b0;
      mode_reg         <= '0;
      tgt_reg          <= '0;
      div_ratio_reg    <= CNT_W'(1);
      apply_d_reg      <= 1'b0;
      mode_changed_reg <= 1'b0;
    end else begin
      enable_reg       <= period_end;
      cnt_reg          <= period_end ? '0 : cnt_reg + 1'b1;
      tgt_reg          <= tgt_next;
      apply_d_reg      <= apply;
      mode_changed_reg <= apply_d_reg;
      if (apply) begin
        mode_reg      <= tgt_reg;
        div_ratio_reg <= div_table[tgt_reg];
      end
    end
  end

  assign Ready       = ready_reg;
  assign Enable      = enable_reg;
  assign Mode        = mode_reg;
  assign ModeChanged = mode_changed_reg;
  assign DivRatio    = div_ratio_reg;

endmodule

// File: tb/tb_sampling_rate_ctrl.sv
// Self-checking bench for sampling_rate_ctrl: scenario tasks plus a
// behavioural monitor of sample period, boundary-only mode changes and ratio.
module tb_sampling_rate_ctrl;

  localparam int NUM_MODES       = 5;
  localparam int RADIX           = 10;
  localparam int MODE_W          = 4;
  localparam int CNT_W           = 15;
  localparam int READY_CYCLES    = 80;
  localparam int DEBOUNCE_CYCLES = 4;

  logic              Fg_CLK   = 1'b0;
  logic              RESET    = 1'b1;
  logic              BtnUp    = 1'b0;
  logic              BtnDown  = 1'b0;
  logic              ModeLoad = 1'b0;
  logic [MODE_W-1:0] ModeIn   = '0;
  logic              Ready;
  logic              Enable;
  logic [MODE_W-1:0] Mode;
  logic              ModeChanged;
  logic [CNT_W-1:0]  DivRatio;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_en_cyc  = 0;
  int last_en_mode = 0;
  logic [MODE_W-1:0] mode_h1 = '0;
  logic [MODE_W-1:0] mode_h2 = '0;
  int L = 0;

  sampling_rate_ctrl #(
    .NUM_MODES(NUM_MODES), .RADIX(RADIX), .MODE_W(MODE_W), .CNT_W(CNT_W),
    .READY_CYCLES(READY_CYCLES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .Fg_CLK(Fg_CLK), .RESET(RESET), .BtnUp(BtnUp), .BtnDown(BtnDown),
    .ModeLoad(ModeLoad), .ModeIn(ModeIn), .Ready(Ready), .Enable(Enable),
    .Mode(Mode), .ModeChanged(ModeChanged), .DivRatio(DivRatio)
  );

  initial forever #5 Fg_CLK = ~Fg_CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int ipow(input int m);
    int r;
    r = 1;
    repeat (m) r = r * RADIX;
    return r;
  endfunction

  // Reference rules: each sample period lasts RADIX**(mode at its start),
  // Mode only moves on an Enable cycle, ModeChanged follows a move by one cycle.
  always @(posedge Fg_CLK) begin : monitor
    logic rst_s;
    rst_s = RESET;
    #1;
    checks++;
    if (DivRatio !== CNT_W'(ipow(int'(Mode)))) begin
      failures++;
      $display("FAIL mon_divratio: got %0d expected %0d", DivRatio, ipow(int'(Mode)));
    end
    if (rst_s) begin
      cyc = 0; last_en_cyc = 0; last_en_mode = 0; mode_h1 = '0; mode_h2 = '0;
    end else begin
      cyc++;
      checks++;
      if (ModeChanged !== (mode_h1 != mode_h2)) begin
        failures++;
        $display("FAIL mon_modechanged: got %0b expected %0b at cyc %0d",
                 ModeChanged, (mode_h1 != mode_h2), cyc);
      end
      checks++;
      if (Mode !== mode_h1 && Enable !== 1'b1) begin
        failures++;
        $display("FAIL mon_boundary: mode moved %0d->%0d without Enable at cyc %0d",
                 mode_h1, Mode, cyc);
      end
      if (Enable === 1'b1) begin
        checks++;
        if (cyc - last_en_cyc != ipow(last_en_mode)) begin
          failures++;
          $display("FAIL mon_period: got %0d expected %0d at cyc %0d",
                   cyc - last_en_cyc, ipow(last_en_mode), cyc);
        end
        last_en_cyc  = cyc;
        last_en_mode = int'(Mode);
      end
      mode_h2 = mode_h1;
      mode_h1 = Mode;
    end
  end

  task automatic step();
    @(posedge Fg_CLK);
    #2;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic wait_mode(input logic [MODE_W-1:0] m, input int budget, output bit ok);
    int n;
    ok = (Mode === m);
    n = 0;
    while (!ok && n < budget) begin
      step();
      n++;
      if (Mode === m) ok = 1'b1;
    end
  endtask

  task automatic press(input logic up, input logic dn, input int hold);
    @(negedge Fg_CLK);
    BtnUp = up; BtnDown = dn;
    repeat (hold) @(negedge Fg_CLK);
    BtnUp = 1'b0; BtnDown = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    cycles(3);
    checks++;
    if (Ready !== 1'b0 || Enable !== 1'b0 || Mode !== '0 || ModeChanged !== 1'b0 || DivRatio !== CNT_W'(1)) begin
      failures++;
      $display("FAIL reset_values: got R%0b E%0b M%0d MC%0b D%0d expected R0 E0 M0 MC0 D1",
               Ready, Enable, Mode, ModeChanged, DivRatio);
    end
    @(negedge Fg_CLK);
    RESET = 1'b0;
    for (int c = 1; c <= READY_CYCLES + 5; c++) begin
      step();
      checks++;
      if (Enable !== 1'b1 || Ready !== (c >= READY_CYCLES) || Mode !== '0) begin
        failures++;
        $display("FAIL reset_startup: cycle %0d got E%0b R%0b M%0d expected E1 R%0b M0",
                 c, Enable, Ready, Mode, (c >= READY_CYCLES));
      end
      if (c == 5) begin
        @(negedge Fg_CLK); ModeLoad = 1'b1; ModeIn = 4'd2;
      end
      if (c == 6) begin
        @(negedge Fg_CLK); ModeLoad = 1'b0;
      end
    end
    $display("test_reset: Ready rose at cycle %0d, mode %0d", READY_CYCLES, Mode);
  endtask

  task automatic test_up_step();
    int hold, mc, e1, e2;
    hold = $urandom_range(10, 16);
    mc = 0; L = 0; e1 = -1; e2 = -1;
    @(negedge Fg_CLK);
    BtnUp = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (ModeChanged === 1'b1) mc++;
      if (L == 0 && Mode !== '0) L = k;
      if (k == hold) begin
        @(negedge Fg_CLK); BtnUp = 1'b0;
      end
    end
    checks++;
    if (L == 0) begin
      failures++;
      $display("FAIL up_latency: got no change expected change within 40 cycles");
    end
    if (L < 2) L = 2;
    checks++;
    if (Mode !== 4'd1 || DivRatio !== CNT_W'(10)) begin
      failures++;
      $display("FAIL up_mode: got M%0d D%0d expected M1 D10", Mode, DivRatio);
    end
    for (int k = 0; k < 25; k++) begin
      step();
      if (ModeChanged === 1'b1) mc++;
      if (Enable === 1'b1) begin
        if (e1 < 0) e1 = k; else if (e2 < 0) e2 = k;
      end
    end
    checks++;
    if (e1 < 0 || e2 < 0 || e2 - e1 != 10) begin
      failures++;
      $display("FAIL up_period: got %0d expected 10", e2 - e1);
    end
    checks++;
    if (mc != 1) begin
      failures++;
      $display("FAIL up_modechanged: got %0d pulses expected 1", mc);
    end
    $display("test_up_step: hold=%0d latency=%0d mode=%0d", hold, L, Mode);
  endtask

  task automatic test_no_change(input string name, input logic up, input logic dn,
                                input int hold, input logic [MODE_W-1:0] exp_mode);
    int mc;
    mc = 0;
    cycles($urandom_range(8, 15));
    press(up, dn, hold);
    for (int k = 0; k < 40; k++) begin
      step();
      if (ModeChanged === 1'b1) mc++;
    end
    checks++;
    if (Mode !== exp_mode || mc != 0) begin
      failures++;
      $display("FAIL %s: got M%0d MC%0d expected M%0d MC0", name, Mode, mc, exp_mode);
    end
    $display("%s: hold=%0d mode=%0d", name, hold, Mode);
  endtask

  task automatic test_hold_long();
    int mc;
    mc = 0;
    cycles($urandom_range(8, 15));
    @(negedge Fg_CLK);
    BtnUp = 1'b1;
    for (int k = 0; k < 200; k++) begin
      step();
      if (ModeChanged === 1'b1) mc++;
    end
    @(negedge Fg_CLK);
    BtnUp = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (ModeChanged === 1'b1) mc++;
    end
    checks++;
    if (Mode !== 4'd2 || mc != 1) begin
      failures++;
      $display("FAIL hold_long: got M%0d MC%0d expected M2 MC1", Mode, mc);
    end
    $display("test_hold_long: mode=%0d pulses=%0d", Mode, mc);
  endtask

  task automatic test_load_priority();
    bit ok;
    cycles($urandom_range(10, 30));
    @(negedge Fg_CLK);
    BtnUp = 1'b1;
    repeat (L - 2) @(posedge Fg_CLK);
    @(negedge Fg_CLK);
    ModeLoad = 1'b1; ModeIn = 4'd1;
    @(negedge Fg_CLK);
    ModeLoad = 1'b0;
    repeat (5) @(negedge Fg_CLK);
    BtnUp = 1'b0;
    wait_mode(4'd1, 150, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL load_priority_apply: got M%0d expected M1", Mode);
    end
    cycles(120);
    checks++;
    if (Mode !== 4'd1) begin
      failures++;
      $display("FAIL load_priority_hold: got M%0d expected M1", Mode);
    end
    $display("test_load_priority: mode=%0d", Mode);
  endtask

  task automatic test_load_sat(output int entry);
    bit ok;
    int p0, n;
    n = 0;
    while (Enable !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (Enable !== 1'b1) begin
      failures++;
      $display("FAIL load_sat_sync: got E%0b expected E1", Enable);
    end
    p0 = cyc;
    cycles($urandom_range(0, 6));
    @(negedge Fg_CLK);
    ModeLoad = 1'b1; ModeIn = 4'd9;
    @(negedge Fg_CLK);
    ModeLoad = 1'b0;
    wait_mode(4'd4, 20, ok);
    entry = cyc;
    checks++;
    if (!ok || cyc - p0 != 10) begin
      failures++;
      $display("FAIL load_sat: got M%0d after %0d cycles expected M4 after 10", Mode, cyc - p0);
    end
    $display("test_load_sat: mode=%0d applied %0d cycles after boundary", Mode, cyc - p0);
  endtask

  task automatic test_wrap_up(input int entry);
    bit ok;
    cycles($urandom_range(5, 20));
    press(1'b1, 1'b0, $urandom_range(10, 14));
    cycles(2000);
    checks++;
    if (Mode !== 4'd4) begin
      failures++;
      $display("FAIL wrap_up_early: got M%0d expected M4", Mode);
    end
    wait_mode(4'd0, 10100, ok);
    checks++;
    if (!ok || cyc - entry != 10000) begin
      failures++;
      $display("FAIL wrap_up: got M%0d after %0d cycles expected M0 after 10000", Mode, cyc - entry);
    end
    $display("test_wrap_up: mode=%0d after %0d cycles", Mode, cyc - entry);
  endtask

  task automatic test_wrap_down();
    bit ok;
    cycles($urandom_range(10, 20));
    press(1'b0, 1'b1, $urandom_range(10, 14));
    wait_mode(4'd4, 40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wrap_down: got M%0d expected M4", Mode);
    end
    $display("test_wrap_down: mode=%0d", Mode);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int w;
    cycles(10);
    @(negedge Fg_CLK);
    ModeLoad = 1'b1; ModeIn = 4'd3;
    @(negedge Fg_CLK);
    ModeLoad = 1'b0;
    wait_mode(4'd3, 10100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_mid_setup: got M%0d expected M3", Mode);
    end
    w = $urandom_range(100, 900);
    cycles(w);
    @(negedge Fg_CLK);
    RESET = 1'b1;
    step();
    checks++;
    if (Ready !== 1'b0 || Enable !== 1'b0 || Mode !== '0 || ModeChanged !== 1'b0 || DivRatio !== CNT_W'(1)) begin
      failures++;
      $display("FAIL reset_mid: got R%0b E%0b M%0d MC%0b D%0d expected R0 E0 M0 MC0 D1",
               Ready, Enable, Mode, ModeChanged, DivRatio);
    end
    @(negedge Fg_CLK);
    RESET = 1'b0;
    step();
    checks++;
    if (Enable !== 1'b1 || Ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_restart: got E%0b R%0b expected E1 R0", Enable, Ready);
    end
    $display("test_reset_mid: reset after %0d cycles at mode 3", w);
  endtask

  initial begin : main
    int entry;
    test_reset();
    test_up_step();
    test_no_change("test_glitch", 1'b1, 1'b0, 3, 4'd1);
    test_no_change("test_both", 1'b1, 1'b1, $urandom_range(10, 14), 4'd1);
    test_hold_long();
    test_load_priority();
    test_load_sat(entry);
    test_wrap_up(entry);
    test_wrap_down();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
